// File: rtl/modulation_pkg.sv
// -----------------------------------------------------------------------------
// modulation_pkg
// Shared definitions for the modulation symbol feeder:
//   - default symbol length and carrier table depth
//   - carrier table (signed Q16: 65536 represents +1.0), one full period
//   - feeder state enum
// -----------------------------------------------------------------------------
package modulation_pkg;

  localparam int DEF_SAMPLES_PER_SYM = 8;
  localparam int DEF_TABLE_DEPTH     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feeder_state_t;

  // One period of the carrier in 8 steps, Q16 signed (sin at 45 degree steps).
  function automatic logic signed [31:0] carrier_q16(input logic [2:0] idx);
    logic signed [31:0] v;
    case (idx)
      3'd0:    v = 32'sd0;
      3'd1:    v = 32'sd46341;
      3'd2:    v = 32'sd65536;
      3'd3:    v = 32'sd46341;
      3'd4:    v = 32'sd0;
      3'd5:    v = -32'sd46341;
      3'd6:    v = -32'sd65536;
      default: v = -32'sd46341;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/carrier_phase_rom.sv
// -----------------------------------------------------------------------------
// carrier_phase_rom
// Registered carrier table lookup. Produces the table sample at i_idx and its
// two's-complement negation one clock later; both read 0 when i_en is low.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_en         lookup enable (feeder in RUN)
//   i_idx        table index
//   o_sample     registered TABLE[i_idx], sign-extended to DATA_W
//   o_sample_m   registered 0 - TABLE[i_idx] modulo 2^DATA_W
// -----------------------------------------------------------------------------
module carrier_phase_rom
  import modulation_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TABLE_DEPTH = DEF_TABLE_DEPTH,
  localparam int IDX_W      = $clog2(TABLE_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_sample,
  output logic [DATA_W-1:0] o_sample_m
);

  logic signed [31:0]       w_tab;
  logic signed [DATA_W-1:0] w_sample;

  // The table holds one 8-step period; the index is taken modulo 8.
  assign w_tab    = carrier_q16(3'(i_idx));
  assign w_sample = DATA_W'(w_tab);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_sample   <= '0;
      o_sample_m <= '0;
    end else if (i_en) begin
      o_sample   <= w_sample;
      o_sample_m <= '0 - w_sample;
    end else begin
      o_sample   <= '0;
      o_sample_m <= '0;
    end
  end

endmodule

// File: rtl/modulation_symbol_feeder.sv
// -----------------------------------------------------------------------------
// modulation_symbol_feeder
// Accepts symbol words over valid/ready, holds each on input_bit for
// SAMPLES_PER_SYM samples while stepping a continuous-phase carrier table.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   sym_valid/ready   upstream handshake (ready registered, = !pending full)
//   sym_data          symbol word
//   input_bit         held symbol word (0 when idle)
//   array_ref_wire    carrier sample; array_ref_m_wire is its negation
//   seg_valid         outputs carry a live sample
//   sym_start/last    first / last sample of a symbol
//   gap_cnt           saturating count of symbol ends with nothing queued
// Pipeline: state regs (cur, phase, idx) feed a second register stage that
// drives every output, so the first sample appears two edges after accept.
// -----------------------------------------------------------------------------
module modulation_symbol_feeder
  import modulation_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int SAMPLES_PER_SYM = DEF_SAMPLES_PER_SYM,
  parameter int TABLE_DEPTH     = DEF_TABLE_DEPTH,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  input  logic [DATA_W-1:0] sym_data,
  output logic              sym_ready,
  output logic [DATA_W-1:0] input_bit,
  output logic [DATA_W-1:0] array_ref_wire,
  output logic [DATA_W-1:0] array_ref_m_wire,
  output logic              seg_valid,
  output logic              sym_start,
  output logic              sym_last,
  output logic [CNT_W-1:0]  gap_cnt
);

  localparam int IDX_W = $clog2(TABLE_DEPTH);
  localparam int PH_W  = $clog2(SAMPLES_PER_SYM);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLES_PER_SYM - 1);

  feeder_state_t     r_state;
  logic [DATA_W-1:0] r_cur;
  logic [DATA_W-1:0] r_nxt;
  logic              r_nxt_valid;
  logic [PH_W-1:0]   r_phase;
  logic [IDX_W-1:0]  r_idx;
  logic              r_gap_evt;
  logic              r_sym_ready;
  logic [DATA_W-1:0] r_input_bit;
  logic              r_seg_valid;
  logic              r_sym_start;
  logic              r_sym_last;
  logic [CNT_W-1:0]  r_gap_cnt;

  logic w_accept;
  logic w_end;
  logic w_load_nxt;
  logic w_load_direct;
  logic w_capture;
  logic w_nxt_valid_d;

  assign w_accept      = sym_valid & r_sym_ready;
  assign w_end         = (r_state == RUN) && (r_phase == PH_LAST);
  // The pending word moves to cur whenever cur is free or finishing.
  assign w_load_nxt    = r_nxt_valid & ((r_state == IDLE) | w_end);
  // A word arriving exactly at a symbol end with nothing pending bypasses nxt.
  assign w_load_direct = w_accept & w_end & ~r_nxt_valid;
  assign w_capture     = w_accept & ~w_load_direct;
  assign w_nxt_valid_d = w_capture | (r_nxt_valid & ~w_load_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_nxt       <= '0;
      r_nxt_valid <= 1'b0;
      r_phase     <= '0;
      r_idx       <= '0;
      r_gap_evt   <= 1'b0;
      r_sym_ready <= 1'b0;
      r_input_bit <= '0;
      r_seg_valid <= 1'b0;
      r_sym_start <= 1'b0;
      r_sym_last  <= 1'b0;
      r_gap_cnt   <= '0;
    end else begin
      r_nxt_valid <= w_nxt_valid_d;
      r_sym_ready <= ~w_nxt_valid_d;
      if (w_capture) r_nxt <= sym_data;
      r_gap_evt <= 1'b0;

      case (r_state)
        IDLE: begin
          r_idx   <= '0;
          r_phase <= '0;
          if (r_nxt_valid) begin
            r_cur   <= r_nxt;
            r_state <= RUN;
          end
        end
        RUN: begin
          // idx runs freely across symbols to keep the carrier phase continuous
          r_idx <= r_idx + IDX_W'(1);
          if (w_end) begin
            r_phase <= '0;
            if (w_load_nxt) begin
              r_cur <= r_nxt;
            end else if (w_load_direct) begin
              r_cur <= sym_data;
            end else begin
              r_state   <= IDLE;
              r_gap_evt <= 1'b1;
            end
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase

      // Output stage, aligned with the ROM's registered sample.
      r_seg_valid <= (r_state == RUN);
      r_input_bit <= (r_state == RUN) ? r_cur : '0;
      r_sym_start <= (r_state == RUN) && (r_phase == '0);
      r_sym_last  <= w_end;
      // Delayed one edge so the count moves after the last sample is shown.
      if (r_gap_evt && (r_gap_cnt != {CNT_W{1'b1}}))
        r_gap_cnt <= r_gap_cnt + CNT_W'(1);
    end
  end

  carrier_phase_rom #(
    .DATA_W      (DATA_W),
    .TABLE_DEPTH (TABLE_DEPTH)
  ) u_rom (
    .clk        (clk),
    .reset      (reset),
    .i_en       (r_state == RUN),
    .i_idx      (r_idx),
    .o_sample   (array_ref_wire),
    .o_sample_m (array_ref_m_wire)
  );

  assign sym_ready = r_sym_ready;
  assign input_bit = r_input_bit;
  assign seg_valid = r_seg_valid;
  assign sym_start = r_sym_start;
  assign sym_last  = r_sym_last;
  assign gap_cnt   = r_gap_cnt;

endmodule

// File: tb/tb_modulation_symbol_feeder.sv
module tb_modulation_symbol_feeder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 8-sample instance
  logic        v8;
  logic [31:0] d8;
  logic        r8, sv8, ss8, sl8;
  logic [31:0] ib8, ar8, am8;
  logic [15:0] gc8;

  // 6-sample instance with a 2-bit gap counter
  logic        v6;
  logic [31:0] d6;
  logic        r6, sv6, ss6, sl6;
  logic [31:0] ib6, ar6, am6;
  logic [1:0]  gc6;

  modulation_symbol_feeder u_dut (
    .clk(clk), .reset(reset), .sym_valid(v8), .sym_data(d8), .sym_ready(r8),
    .input_bit(ib8), .array_ref_wire(ar8), .array_ref_m_wire(am8),
    .seg_valid(sv8), .sym_start(ss8), .sym_last(sl8), .gap_cnt(gc8)
  );

  modulation_symbol_feeder #(.SAMPLES_PER_SYM(6), .CNT_W(2)) u_dut6 (
    .clk(clk), .reset(reset), .sym_valid(v6), .sym_data(d6), .sym_ready(r6),
    .input_bit(ib6), .array_ref_wire(ar6), .array_ref_m_wire(am6),
    .seg_valid(sv6), .sym_start(ss6), .sym_last(sl6), .gap_cnt(gc6)
  );

  int checks = 0;
  int errors = 0;

  // Hand-written carrier values (Q16)
  int exp_tab [8] = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};

  logic [31:0] words [3] = '{32'h10, 32'h20, 32'h30};
  logic [31:0] seen [$];
  int          widx, first, last, hits;
  bit          saw_block, acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    v8 = 1'b0;
    v6 = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v8 = 1'b0; d8 = '0; v6 = 1'b0; d6 = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(r8), 32'd0);
    chk("rst_seg_valid", 32'(sv8), 32'd0);
    chk("rst_input_bit", ib8, 32'd0);
    chk("rst_ref", ar8, 32'd0);
    chk("rst_ref_m", am8, 32'd0);
    chk("rst_start_last", 32'({ss8, sl8}), 32'd0);
    chk("rst_gap", 32'(gc8), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 32'(r8), 32'd1);

    // Single word: 8 samples then idle with one gap
    v8 = 1'b1; d8 = 32'h1;
    tick();
    v8 = 1'b0;
    chk("t1_ready_drop", 32'(r8), 32'd0);
    tick();
    chk("t1_latency", 32'(sv8), 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t1_valid[%0d]", k), 32'(sv8), 32'd1);
      chk($sformatf("t1_bit[%0d]", k), ib8, 32'h1);
      chk($sformatf("t1_ref[%0d]", k), ar8, 32'(exp_tab[k]));
      chk($sformatf("t1_ref_m[%0d]", k), am8, 32'(-exp_tab[k]));
      chk($sformatf("t1_start[%0d]", k), 32'(ss8), 32'(k == 0));
      chk($sformatf("t1_last[%0d]", k), 32'(sl8), 32'(k == 7));
      chk($sformatf("t1_gap[%0d]", k), 32'(gc8), 32'd0);
      tick();
    end
    chk("t1_end_valid", 32'(sv8), 32'd0);
    chk("t1_end_gap", 32'(gc8), 32'd1);
    chk("t1_end_bit", ib8, 32'd0);

    // Two words back to back: 16 gapless samples, continuous carrier
    do_reset();
    v8 = 1'b1; d8 = 32'hA;
    tick();
    d8 = 32'hB;
    tick();
    chk("t2_latency", 32'(sv8), 32'd0);
    tick();
    v8 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t2_valid[%0d]", k), 32'(sv8), 32'd1);
      chk($sformatf("t2_bit[%0d]", k), ib8, (k < 8) ? 32'hA : 32'hB);
      chk($sformatf("t2_ref[%0d]", k), ar8, 32'(exp_tab[k % 8]));
      chk($sformatf("t2_start[%0d]", k), 32'(ss8), 32'((k % 8) == 0));
      chk($sformatf("t2_last[%0d]", k), 32'(sl8), 32'((k % 8) == 7));
      chk($sformatf("t2_gap[%0d]", k), 32'(gc8), 32'd0);
      tick();
    end
    chk("t2_end_valid", 32'(sv8), 32'd0);
    chk("t2_end_gap", 32'(gc8), 32'd1);

    // Three words offered continuously
    do_reset();
    widx = 0; first = -1; last = -1; saw_block = 1'b0;
    seen.delete();
    v8 = 1'b1; d8 = words[0];
    for (int c = 0; c < 40; c++) begin
      acc = v8 && r8;
      if (v8 && !r8 && widx > 0) saw_block = 1'b1;
      if (sv8) begin
        seen.push_back(ib8);
        if (first < 0) first = c;
        last = c;
      end
      tick();
      if (acc) begin
        widx++;
        if (widx < 3) d8 = words[widx];
        else v8 = 1'b0;
      end
    end
    chk("t3_accepted", 32'(widx), 32'd3);
    chk("t3_samples", 32'(seen.size()), 32'd24);
    chk("t3_contiguous", 32'(last - first + 1), 32'd24);
    chk("t3_ready_blocked", 32'(saw_block), 32'd1);
    for (int i = 0; i < seen.size(); i++) begin
      if (i < 24) chk($sformatf("t3_order[%0d]", i), seen[i], words[i / 8]);
    end
    chk("t3_end_gap", 32'(gc8), 32'd1);

    // Reset mid-symbol with a word pending
    do_reset();
    v8 = 1'b1; d8 = 32'h55;
    tick();
    d8 = 32'h66;
    tick();
    tick();
    v8 = 1'b0;
    chk("t4_start", 32'(ss8), 32'd1);
    chk("t4_bit", ib8, 32'h55);
    chk("t4_pending", 32'(r8), 32'd0);
    tick(); tick(); tick();
    chk("t4_phase3_ref", ar8, 32'(exp_tab[3]));
    reset = 1'b1;
    tick();
    chk("t4_rst_valid", 32'(sv8), 32'd0);
    chk("t4_rst_ready", 32'(r8), 32'd0);
    chk("t4_rst_bit", ib8, 32'd0);
    chk("t4_rst_ref", ar8, 32'd0);
    chk("t4_rst_ref_m", am8, 32'd0);
    chk("t4_rst_start_last", 32'({ss8, sl8}), 32'd0);
    reset = 1'b0;
    tick();
    chk("t4_ready_release", 32'(r8), 32'd1);
    hits = 0;
    repeat (20) begin
      if (sv8) hits++;
      if (ib8 !== 32'd0) hits++;
      tick();
    end
    chk("t4_pending_dropped", 32'(hits), 32'd0);
    chk("t4_gap", 32'(gc8), 32'd0);

    // SAMPLES_PER_SYM = 6: carrier continues into the second symbol
    do_reset();
    v6 = 1'b1; d6 = 32'h100;
    tick();
    d6 = 32'h200;
    tick();
    chk("t5_latency", 32'(sv6), 32'd0);
    tick();
    v6 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t5_valid[%0d]", k), 32'(sv6), 32'd1);
      chk($sformatf("t5_bit[%0d]", k), ib6, (k < 6) ? 32'h100 : 32'h200);
      chk($sformatf("t5_ref[%0d]", k), ar6, 32'(exp_tab[k % 8]));
      chk($sformatf("t5_ref_m[%0d]", k), am6, 32'(-exp_tab[k % 8]));
      chk($sformatf("t5_start[%0d]", k), 32'(ss6), 32'((k % 6) == 0));
      chk($sformatf("t5_last[%0d]", k), 32'(sl6), 32'((k % 6) == 5));
      tick();
    end
    chk("t5_end_valid", 32'(sv6), 32'd0);
    chk("t5_end_gap", 32'(gc6), 32'd1);

    // Gap counter saturation on the 2-bit instance: 1 + 4 events caps at 3
    for (int w = 0; w < 4; w++) begin
      v6 = 1'b1; d6 = 32'(w + 1);
      tick();
      v6 = 1'b0;
      repeat (11) tick();
      if (w == 1) chk("t6_gap_mid", 32'(gc6), 32'd3);
    end
    chk("t6_gap_sat", 32'(gc6), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
